i2s_capture: RTL and testbench

- I2S receive path (record side) for the audio front end, operating in slave mode: sclk and ws are inputs, both oversampled by the system clock clk.
- Deserializes sdi into 16-bit samples and writes them into a word buffer. The addressing is compatible with the playback path's 32-word buffer.
- ws is active-high, as in the playback path: ws high marks an active word.
- Reports complete-buffer events and malformed (short) words.

---
 rtl/i2s_pkg.sv | 20 ++
 rtl/i2s_edge_sync.sv | 37 +++
 rtl/i2s_capture.sv | 206 ++++++++++++++++++++
 tb/tb_i2s_capture.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared I2S constants and types for the record (capture) and playback paths.
//   I2S_DATA_W  : sample width in bits
//   I2S_ADDR_W  : word-buffer address width (buffer depth 2**I2S_ADDR_W)
//   cap_state_t : capture FSM state encoding
// -----------------------------------------------------------------------------
package i2s_pkg;

    localparam int I2S_DATA_W = 16;
    localparam int I2S_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SHIFT,
        DONE
    } cap_state_t;

endpackage

// File: rtl/i2s_edge_sync.sv
// -----------------------------------------------------------------------------
// i2s_edge_sync
// Three-flop synchronizer for an asynchronous single-bit input, with
// one-clk rise/fall pulses derived from the two settled stages.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   din      in   asynchronous input
//   sync     out  synchronized level (stage 1, aligned with the edge pulses)
//   rise     out  one-clk pulse on a 0->1 transition
//   fall     out  one-clk pulse on a 1->0 transition
// -----------------------------------------------------------------------------
module i2s_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    // Stage 1 is the newer settled sample, stage 2 the older one.
    assign sync = sync_q[1];
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/i2s_capture.sv
// -----------------------------------------------------------------------------
// i2s_capture
// I2S slave receive path: oversamples sclk/ws/sdi on clk, deserializes one
// DATA_W-bit word (MSB first, after the one-bit I2S delay slot) per ws-high
// period and writes it into a 2**ADDR_W word buffer with a wrapping pointer.
// Optional build macro I2S_CAPTURE_PEAK_EN adds a saturating |sample| peak
// meter (peak_level / peak_clr).
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   en                  capture enable (checked in IDLE, aborts elsewhere)
//   sclk, ws, sdi       I2S bit clock, word select (active high), data
//   wr_en               one-clk buffer write strobe
//   wr_addr, wr_data    buffer write address / captured sample
//   frame_done          one-clk pulse with the write to the last address
//   short_err, err_clr  sticky short-word flag and its clear
//   peak_level, peak_clr  (I2S_CAPTURE_PEAK_EN only) peak |sample| and clear
// -----------------------------------------------------------------------------
module i2s_capture
    import i2s_pkg::*;
#(
    parameter int DATA_W = I2S_DATA_W,
    parameter int ADDR_W = I2S_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              sclk,
    input  logic              ws,
    input  logic              sdi,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              short_err,
    input  logic              err_clr
`ifdef I2S_CAPTURE_PEAK_EN
    ,
    output logic [DATA_W-2:0] peak_level,
    input  logic              peak_clr
`endif
);

    localparam int CNT_W = $clog2(DATA_W);

    logic sclk_re, sclk_s_unused, sclk_fe_unused;
    logic ws_re, ws_fe, ws_s_unused;
    logic sdi_s, sdi_re_unused, sdi_fe_unused;

    i2s_edge_sync u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sclk),
        .sync    (sclk_s_unused),
        .rise    (sclk_re),
        .fall    (sclk_fe_unused)
    );

    i2s_edge_sync u_sync_ws (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (ws),
        .sync    (ws_s_unused),
        .rise    (ws_re),
        .fall    (ws_fe)
    );

    i2s_edge_sync u_sync_sdi (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sdi),
        .sync    (sdi_s),
        .rise    (sdi_re_unused),
        .fall    (sdi_fe_unused)
    );

    cap_state_t        state_q, state_d;
    logic [CNT_W-1:0]  bitcnt;
    logic [DATA_W-2:0] shreg;     // only the first DATA_W-1 bits are stored; the last comes straight from sdi_s
    logic [ADDR_W-1:0] ptr;
    logic              do_shift, do_write, clr_cnt, err_set;
    logic              last_bit;

    assign last_bit = (bitcnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority inside a word: en drop, then ws re-entry, then the bit clock
    // (so a final bit coinciding with ws_fe still writes), then ws_fe.
    always_comb begin
        state_d  = state_q;
        do_shift = 1'b0;
        do_write = 1'b0;
        clr_cnt  = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ws_re && en) state_d = DELAY;
            end
            DELAY: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (ws_fe) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else if (ws_re) begin
                    state_d = DELAY;
                end else if (sclk_re) begin
                    clr_cnt = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (ws_re) begin
                    state_d = DELAY;
                end else if (sclk_re && last_bit) begin
                    do_shift = 1'b1;
                    do_write = 1'b1;
                    state_d  = ws_fe ? IDLE : DONE;
                end else if (ws_fe) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else if (sclk_re) begin
                    do_shift = 1'b1;
                end
            end
            DONE: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (ws_re) begin
                    state_d = DELAY;
                end else if (ws_fe) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitcnt     <= '0;
            shreg      <= '0;
            ptr        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            short_err  <= 1'b0;
        end else begin
            wr_en      <= do_write;
            frame_done <= do_write && (ptr == '1);
            if (clr_cnt) begin
                bitcnt <= '0;
            end else if (do_shift) begin
                bitcnt <= bitcnt + CNT_W'(1);
            end
            if (do_shift) begin
                shreg <= {shreg[DATA_W-3:0], sdi_s};
            end
            if (do_write) begin
                wr_data <= {shreg, sdi_s};
                wr_addr <= ptr;
                ptr     <= ptr + ADDR_W'(1);
            end
            if (err_set) begin
                short_err <= 1'b1;
            end else if (err_clr) begin
                short_err <= 1'b0;
            end
        end
    end

`ifdef I2S_CAPTURE_PEAK_EN
    // Magnitude of a two's-complement sample; the most negative code has no
    // positive counterpart and saturates to the largest magnitude.
    function automatic logic [DATA_W-2:0] sat_abs(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] neg;
        neg = -x;
        if (x[DATA_W-1] && (x[DATA_W-2:0] == '0)) return '1;
        else if (x[DATA_W-1]) return neg[DATA_W-2:0];
        else return x[DATA_W-2:0];
    endfunction

    logic [DATA_W-2:0] wr_abs;
    assign wr_abs = sat_abs(wr_data);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_level <= '0;
        end else if (peak_clr) begin
            peak_level <= wr_en ? wr_abs : '0;
        end else if (wr_en && (wr_abs > peak_level)) begin
            peak_level <= wr_abs;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_capture.sv
// -----------------------------------------------------------------------------
// tb_i2s_capture
// Directed + randomized bench for i2s_capture. I2S traffic is produced by
// tasks (ws/sdi change on sclk falling edges); a monitor logs every write and
// the expected writes, pointer, error flag and peak come from a word-level
// model of the capture rules.
// -----------------------------------------------------------------------------
module tb_i2s_capture;
    import i2s_pkg::*;

    localparam int DATA_W = I2S_DATA_W;
    localparam int ADDR_W = I2S_ADDR_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int HALF   = 4;   // clk cycles per sclk half period

    logic              clk = 1'b0;
    logic              reset_n, en, sclk, ws, sdi, err_clr;
    logic              wr_en, frame_done, short_err;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
`ifdef I2S_CAPTURE_PEAK_EN
    logic [DATA_W-2:0] peak_level;
    logic              peak_clr;
`endif

    always #5 clk = ~clk;

    i2s_capture dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .sclk       (sclk),
        .ws         (ws),
        .sdi        (sdi),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .short_err  (short_err),
        .err_clr    (err_clr)
`ifdef I2S_CAPTURE_PEAK_EN
        ,
        .peak_level (peak_level),
        .peak_clr   (peak_clr)
`endif
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              fd;
    } wr_t;

    wr_t mon_q[$];
    int  fd_cnt = 0;

    always @(negedge clk) begin
        if (wr_en) mon_q.push_back({wr_addr, wr_data, frame_done});
        if (frame_done) fd_cnt++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Word-level reference state
    int m_ptr   = 0;
    bit m_err   = 1'b0;
    int m_peak  = 0;
    int m_fd    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_abs(input logic [DATA_W-1:0] d);
        int v;
        v = int'($signed(d));
        if (v < 0) v = -v;
        if (v > (1 << (DATA_W - 1)) - 1) v = (1 << (DATA_W - 1)) - 1;
        return v;
    endfunction

    task automatic half_period();
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic sclk_period(input logic w, input logic d);
        sclk = 1'b0;
        ws   = w;
        sdi  = d;
        half_period();
        sclk = 1'b1;
        half_period();
    endtask

    // One ws-high period: delay slot, then nbits bits (MSB of 'bits' window
    // first), then two ws-low periods. en is dropped before bit en_drop if
    // en_drop >= 0. Afterwards the logged writes are compared with the model.
    task automatic send_frame(input logic [31:0] bits, input int nbits, input int en_drop,
                              input string tag);
        bit                started;
        int                exp_n;
        logic [DATA_W-1:0] exp_data;
        int                exp_addr;
        started = en;
        sclk_period(1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < nbits; i++) begin
            if (i == en_drop) en = 1'b0;
            sclk_period(1'b1, bits[nbits-1-i]);
        end
        sclk_period(1'b0, 1'b0);
        sclk_period(1'b0, 1'b0);

        exp_n    = 0;
        exp_data = '0;
        exp_addr = m_ptr;
        if (started && en_drop < 0) begin
            if (nbits >= DATA_W) begin
                exp_n    = 1;
                exp_data = DATA_W'(bits >> (nbits - DATA_W));
                if (m_ptr == DEPTH - 1) m_fd++;
                m_ptr    = (m_ptr + 1) % DEPTH;
                if (ref_abs(exp_data) > m_peak) m_peak = ref_abs(exp_data);
            end else begin
                m_err = 1'b1;
            end
        end

        check({tag, ".count"}, mon_q.size(), exp_n);
        if (mon_q.size() > 0 && exp_n > 0) begin
            check({tag, ".data"}, mon_q[0].data, exp_data);
            check({tag, ".addr"}, mon_q[0].addr, exp_addr);
            check({tag, ".frame_done"}, mon_q[0].fd, (exp_addr == DEPTH - 1));
        end
        check({tag, ".short_err"}, short_err, m_err);
`ifdef I2S_CAPTURE_PEAK_EN
        check({tag, ".peak"}, peak_level, m_peak);
`endif
        mon_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".wr_en"}, wr_en, 0);
        check({tag, ".wr_addr"}, wr_addr, 0);
        check({tag, ".wr_data"}, wr_data, 0);
        check({tag, ".frame_done"}, frame_done, 0);
        check({tag, ".short_err"}, short_err, 0);
`ifdef I2S_CAPTURE_PEAK_EN
        check({tag, ".peak"}, peak_level, 0);
`endif
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        ws      = 1'b0;
        sclk    = 1'b0;
        sdi     = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        m_ptr   = 0;
        m_err   = 1'b0;
        m_peak  = 0;
        mon_q.delete();
        sclk_period(1'b0, 1'b0);
        sclk_period(1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b1;
        sclk    = 1'b0;
        ws      = 1'b0;
        sdi     = 1'b0;
        err_clr = 1'b0;
`ifdef I2S_CAPTURE_PEAK_EN
        peak_clr = 1'b0;
`endif
        apply_reset();

        // Single word
        send_frame(32'hA5C3, 16, -1, "word_a5c3");

        // 32 consecutive words from address 0, then wrap
        apply_reset();
        for (int i = 0; i < DEPTH; i++) send_frame(32'(i), 16, -1, $sformatf("seq%0d", i));
        send_frame(32'h0000_7E57, 16, -1, "wrap");
        check("frame_done_total", fd_cnt, m_fd);

        // Short word, clear, then a normal word
        send_frame(32'h0000_02AA, 9, -1, "short");
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        m_err = 1'b0;
        check("err_clr", short_err, 0);
        send_frame(32'h1234, 16, -1, "after_clr");

        // Surplus bits after the word are discarded
        send_frame(32'h000B_EEFF, 20, -1, "surplus");

        // en low for a whole word, en dropped mid-word, pointer retained
        en = 1'b0;
        send_frame(32'h0000_C0DE, 16, -1, "en_off");
        en = 1'b1;
        send_frame(32'h0000_F00D, 16, 6, "en_drop");
        en = 1'b1;
        sclk_period(1'b0, 1'b0);
        send_frame(32'h0000_0BAD, 16, -1, "en_back");

        // Reset in the middle of a word flushes everything
        sclk_period(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) sclk_period(1'b1, 1'(i & 1));
        apply_reset();
        send_frame(32'h5A5A, 16, -1, "post_reset");

        // Randomized words of random length (some short, some with surplus)
        for (int i = 0; i < 8; i++) begin
            int nb;
            nb = int'($urandom_range(12, 20));
            send_frame($urandom, nb, -1, $sformatf("rand%0d_n%0d", i, nb));
            if (m_err) begin
                @(posedge clk);
                #1 err_clr = 1'b1;
                @(posedge clk);
                #1 err_clr = 1'b0;
                m_err = 1'b0;
                check("rand_err_clr", short_err, 0);
            end
        end

`ifdef I2S_CAPTURE_PEAK_EN
        apply_reset();
        send_frame(32'h0100, 16, -1, "peak_0100");
        check("peak_after_0100", peak_level, 16'h0100);
        send_frame(32'hFF00, 16, -1, "peak_ff00");
        check("peak_after_ff00", peak_level, 16'h0100);
        send_frame(32'h8000, 16, -1, "peak_8000");
        check("peak_after_8000", peak_level, 16'h7FFF);
        @(posedge clk);
        #1 peak_clr = 1'b1;
        @(posedge clk);
        #1 peak_clr = 1'b0;
        m_peak = 0;
        check("peak_clr", peak_level, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends on its own
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
